rom_pattern_sequencer: RTL

//   Address sequencer and output register that sits in front of the team's asynchronous single-port ROM.

---
 rtl/rom_pattern_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/rom_pattern_sequencer.sv
// rom_pattern_sequencer: steps an asynchronous ROM address at a programmable
// rate and captures each word into a registered output. It supports
// one-shot and looping playback of the full image.
module rom_pattern_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int TICK_DIV   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(TICK_DIV) + 1;
  localparam logic [CW-1:0]         CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [ADDR_WIDTH-1:0]   addr_n;
  logic [DATA_WIDTH-1:0]   dout_n;
  logic                    dout_valid_n;
  logic                    busy_n;
  logic                    done_n;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    addr_n       = addr;
    dout_n       = dout;
    dout_valid_n = 1'b0;
    done_n       = 1'b0;
    busy_n       = busy;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_n = FETCH;
          addr_n  = '0;
          cnt_n   = '0;
          busy_n  = 1'b1;
        end
      end
      FETCH: begin
        if (stop) begin
          state_n = IDLE;
          addr_n  = '0;
          cnt_n   = '0;
          busy_n  = 1'b0;
        end else begin
          state_n      = HOLD;
          dout_n       = rom_q;
          dout_valid_n = 1'b1;
          cnt_n        = '0;
        end
      end
      HOLD: begin
        if (stop) begin
          state_n = IDLE;
          addr_n  = '0;
          cnt_n   = '0;
          busy_n  = 1'b0;
        end else if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (addr != ADDR_MAX) begin
            addr_n  = addr + ADDR_WIDTH'(1);
            state_n = FETCH;
          end else if (loop) begin
            addr_n  = '0;
            state_n = FETCH;
          end else begin
            addr_n  = '0;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        addr_n  = '0;
        cnt_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      addr       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      addr       <= addr_n;
      dout       <= dout_n;
      dout_valid <= dout_valid_n;
      done       <= done_n;
      busy       <= busy_n;
    end
  end

endmodule
